// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory / write-back stage.
package mem_wb_stage_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned AddrWDefault = 8;

  // Stack operation encoding carried on in_SP; 2'b11 behaves like no-op.
  typedef enum logic [1:0] {
    SpNone = 2'b00,
    SpPush = 2'b01,
    SpPop  = 2'b10,
    SpNop  = 2'b11
  } sp_op_e;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Single-port synchronous RAM, read-first, registered read data.
module mem_wb_stage_data_mem #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register samples the pre-write contents (read-first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage: data memory, stack pointer, output port and the MEM/WB latch.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned            DATA_W   = DataWDefault,
  parameter int unsigned            ADDR_W   = AddrWDefault,
  parameter logic [ADDR_W-1:0]      SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        in_ra,
  input  logic [1:0]        in_rb,
  input  logic [DATA_W-1:0] in_R_ra,
  input  logic [DATA_W-1:0] in_R_rb,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_RW,
  input  logic [1:0]        in_SP,
  input  logic              in_SW1,
  input  logic              in_SW2,
  input  logic              in_out_ld,
  input  logic              in_MW,
  input  logic              in_SM1,
  input  logic              in_SM2,
  output logic [1:0]        ra,
  output logic [1:0]        rb,
  output logic [DATA_W-1:0] R_ra,
  output logic [DATA_W-1:0] R_rb,
  output logic              RW,
  output logic              SW1,
  output logic              SW2,
  output logic [DATA_W-1:0] res,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] sp,
  output logic [DATA_W-1:0] out_port
);

  sp_op_e            sp_op;
  logic [ADDR_W-1:0] stack_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] out_q;
  logic [1:0]        ra_q, rb_q;
  logic [DATA_W-1:0] r_ra_q, r_rb_q, res_q;
  logic              rw_q, sw1_q, sw2_q;

  assign sp_op = sp_op_e'(in_SP);

  // Address / data selection and next stack pointer.
  always_comb begin
    stack_addr = sp_q;
    sp_d       = sp_q;
    unique case (sp_op)
      SpPush: sp_d = sp_q - ADDR_W'(1);
      SpPop: begin
        stack_addr = sp_q + ADDR_W'(1);
        sp_d       = sp_q + ADDR_W'(1);
      end
      default: ;
    endcase
    mem_addr  = in_SM1 ? stack_addr : in_res[ADDR_W-1:0];
    mem_wdata = in_SM2 ? in_res : in_R_rb;
    // Gating with rst drops a write that coincides with reset.
    mem_we    = in_MW & ~stall & ~rst;
  end

  mem_wb_stage_data_mem #(
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_data_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (~stall),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_data)
  );

  // Stack pointer, output port and MEM/WB latch; all hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= SP_RESET;
      out_q  <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      r_ra_q <= '0;
      r_rb_q <= '0;
      res_q  <= '0;
      rw_q   <= 1'b0;
      sw1_q  <= 1'b0;
      sw2_q  <= 1'b0;
    end else if (!stall) begin
      sp_q   <= sp_d;
      if (in_out_ld) begin
        out_q <= in_R_rb;
      end
      ra_q   <= in_ra;
      rb_q   <= in_rb;
      r_ra_q <= in_R_ra;
      r_rb_q <= in_R_rb;
      res_q  <= in_res;
      rw_q   <= in_RW;
      sw1_q  <= in_SW1;
      sw2_q  <= in_SW2;
    end
  end

  assign sp       = sp_q;
  assign out_port = out_q;
  assign ra       = ra_q;
  assign rb       = rb_q;
  assign R_ra     = r_ra_q;
  assign R_rb     = r_rb_q;
  assign res      = res_q;
  assign RW       = rw_q;
  assign SW1      = sw1_q;
  assign SW2      = sw2_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic       clk, rst, stall;
  logic [1:0] in_ra, in_rb, in_SP;
  logic [7:0] in_R_ra, in_R_rb, in_res;
  logic       in_RW, in_SW1, in_SW2, in_out_ld, in_MW, in_SM1, in_SM2;
  logic [1:0] ra, rb;
  logic [7:0] R_ra, R_rb, res, mem_data, sp, out_port;
  logic       RW, SW1, SW2;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_R_ra   (in_R_ra),
    .in_R_rb   (in_R_rb),
    .in_res    (in_res),
    .in_RW     (in_RW),
    .in_SP     (in_SP),
    .in_SW1    (in_SW1),
    .in_SW2    (in_SW2),
    .in_out_ld (in_out_ld),
    .in_MW     (in_MW),
    .in_SM1    (in_SM1),
    .in_SM2    (in_SM2),
    .ra        (ra),
    .rb        (rb),
    .R_ra      (R_ra),
    .R_rb      (R_rb),
    .RW        (RW),
    .SW1       (SW1),
    .SW2       (SW2),
    .res       (res),
    .mem_data  (mem_data),
    .sp        (sp),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [1:0] sp_op;
    logic       sm1, sm2, mw, out_ld;
    logic [7:0] res, r_rb;
    logic       chk_mem;
    logic [7:0] e_mem, e_sp, e_out;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; in_ra = 0; in_rb = 0; in_R_ra = 0; in_R_rb = 0; in_res = 0;
    in_RW = 0; in_SP = 0; in_SW1 = 0; in_SW2 = 0; in_out_ld = 0;
    in_MW = 0; in_SM1 = 0; in_SM2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [30:0] exp_pipe;

  initial begin
    //           stall op    sm1 sm2 mw ld res    r_rb   chk e_mem  e_sp   e_out
    vecs[0]  = '{0, 2'b00, 0, 0, 1, 0, 8'h10, 8'hA5, 0, 8'h00, 8'hFF, 8'h00};
    vecs[1]  = '{0, 2'b00, 0, 0, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 8'hFF, 8'h00};
    vecs[2]  = '{0, 2'b01, 1, 0, 1, 0, 8'h00, 8'h3C, 0, 8'h00, 8'hFE, 8'h00};
    vecs[3]  = '{0, 2'b10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h3C, 8'hFF, 8'h00};
    vecs[4]  = '{0, 2'b00, 0, 0, 1, 0, 8'h20, 8'h11, 0, 8'h00, 8'hFF, 8'h00};
    vecs[5]  = '{0, 2'b00, 0, 0, 1, 0, 8'h20, 8'h22, 1, 8'h11, 8'hFF, 8'h00};
    vecs[6]  = '{0, 2'b00, 0, 0, 0, 0, 8'h20, 8'h00, 1, 8'h22, 8'hFF, 8'h00};
    vecs[7]  = '{0, 2'b00, 0, 0, 0, 1, 8'h10, 8'h5A, 1, 8'hA5, 8'hFF, 8'h5A};
    vecs[8]  = '{0, 2'b00, 0, 1, 1, 0, 8'h30, 8'h77, 0, 8'h00, 8'hFF, 8'h5A};
    vecs[9]  = '{0, 2'b00, 0, 0, 0, 0, 8'h30, 8'h00, 1, 8'h30, 8'hFF, 8'h5A};
    vecs[10] = '{1, 2'b01, 1, 0, 1, 1, 8'h30, 8'hEE, 1, 8'h30, 8'hFF, 8'h5A};
    vecs[11] = '{0, 2'b00, 0, 0, 0, 0, 8'h30, 8'h00, 1, 8'h30, 8'hFF, 8'h5A};
    vecs[12] = '{0, 2'b01, 0, 0, 0, 0, 8'h10, 8'h00, 1, 8'hA5, 8'hFE, 8'h5A};
    vecs[13] = '{0, 2'b10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h3C, 8'hFF, 8'h5A};
    vecs[14] = '{0, 2'b10, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h5A};
    vecs[15] = '{0, 2'b01, 1, 0, 1, 0, 8'h00, 8'h9D, 0, 8'h00, 8'hFF, 8'h5A};
    vecs[16] = '{0, 2'b10, 1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h9D, 8'h00, 8'h5A};

    idle_inputs();
    rst = 1'b1;
    #3;
    check("reset_sp", 32'(sp), 32'hFF);
    check("reset_mem_data", 32'(mem_data), 32'h0);
    check("reset_out_port", 32'(out_port), 32'h0);
    check("reset_pipe", 32'({ra, rb, R_ra, R_rb, RW, SW1, SW2, res}), 32'h0);
    step();
    rst = 1'b0;
    exp_pipe = '0;

    for (int i = 0; i < NVec; i++) begin
      logic [7:0] iv;
      iv        = 8'(i);
      stall     = vecs[i].stall;
      in_SP     = vecs[i].sp_op;
      in_SM1    = vecs[i].sm1;
      in_SM2    = vecs[i].sm2;
      in_MW     = vecs[i].mw;
      in_out_ld = vecs[i].out_ld;
      in_res    = vecs[i].res;
      in_R_rb   = vecs[i].r_rb;
      in_ra     = iv[1:0];
      in_rb     = ~iv[1:0];
      in_R_ra   = iv * 8'd7 + 8'd3;
      in_RW     = iv[0];
      in_SW1    = iv[1];
      in_SW2    = iv[2];
      if (!vecs[i].stall)
        exp_pipe = {in_ra, in_rb, in_R_ra, in_R_rb, in_RW, in_SW1, in_SW2, in_res};
      step();
      if (vecs[i].chk_mem)
        check($sformatf("v%0d_mem_data", i), 32'(mem_data), 32'(vecs[i].e_mem));
      check($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].e_sp));
      check($sformatf("v%0d_out_port", i), 32'(out_port), 32'(vecs[i].e_out));
      check($sformatf("v%0d_pipe", i), 32'({ra, rb, R_ra, R_rb, RW, SW1, SW2, res}),
            32'(exp_pipe));
    end

    // Reset mid-run after pushes, then a store held under reset must be dropped.
    idle_inputs();
    in_SP = 2'b01; in_SM1 = 1; in_MW = 1; in_R_rb = 8'h44; in_RW = 1; in_res = 8'h66;
    step();
    check("push_wrap_sp", 32'(sp), 32'hFF);
    step();
    check("push2_sp", 32'(sp), 32'hFE);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sp", 32'(sp), 32'hFF);
    check("async_rst_mem_data", 32'(mem_data), 32'h0);
    check("async_rst_res", 32'(res), 32'h0);
    check("async_rst_RW", 32'(RW), 32'h0);
    check("async_rst_out_port", 32'(out_port), 32'h0);
    idle_inputs();
    in_MW = 1; in_res = 8'h10; in_R_rb = 8'hFF;
    step();
    check("rst_held_sp", 32'(sp), 32'hFF);
    rst = 1'b0;
    idle_inputs();
    in_res = 8'h10;
    step();
    check("write_aborted_by_rst", 32'(mem_data), 32'hA5);
    in_SP = 2'b10; in_SM1 = 1; in_res = 8'h00;
    step();
    check("pop_after_rst_mem", 32'(mem_data), 32'h44);
    check("pop_after_rst_sp", 32'(sp), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
